// File: rtl/n2r_buffer_stream.sv
// Streaming row-to-block buffer: ping-pong slice banks filled one row per beat,
// drained as one BLOCK_SIZE x BLOCK_SIZE chunk per core per output beat.
module n2r_buffer_stream #(
    parameter int WIDTH      = 16,
    parameter int BLOCK_SIZE = 2,
    parameter int NUM_CORES  = 2,
    parameter int ROW        = 10,
    parameter int COL        = 8,
    localparam int CHUNK_SIZE = BLOCK_SIZE * BLOCK_SIZE,
    localparam int SLICE_ROWS = BLOCK_SIZE * NUM_CORES,
    localparam int NUM_SLICES = (ROW + SLICE_ROWS - 1) / SLICE_ROWS
) (
    input  logic                                      clk,
    input  logic                                      rst_n,
    input  logic                                      en,
    input  logic                                      in_valid,
    output logic                                      in_ready,
    input  logic [WIDTH*COL-1:0]                      in_data,
    output logic                                      out_valid,
    input  logic                                      out_ready,
    output logic [WIDTH*CHUNK_SIZE*NUM_CORES-1:0]     out_data,
    output logic                                      out_last,
    output logic                                      frame_done,
    output logic [$clog2(NUM_SLICES):0]               slice_idx
);

    localparam int CHUNKS_PER_ROW = COL / BLOCK_SIZE;
    localparam int PAD_ROWS       = NUM_SLICES * SLICE_ROWS - ROW;
    localparam int CW             = WIDTH * CHUNK_SIZE;
    localparam int RW             = (SLICE_ROWS > 1) ? $clog2(SLICE_ROWS) : 1;
    localparam int FW             = (ROW > 1) ? $clog2(ROW) : 1;
    localparam int KW             = (CHUNKS_PER_ROW > 1) ? $clog2(CHUNKS_PER_ROW) : 1;
    localparam int SW             = $clog2(NUM_SLICES) + 1;

    if (COL % BLOCK_SIZE != 0) begin : g_col_check
        $error("COL must be a multiple of BLOCK_SIZE");
    end

    typedef enum logic {W_FILL, W_PAD} wstate_t;
    typedef enum logic {R_IDLE, R_OUT} rstate_t;

    logic [COL*WIDTH-1:0] mem [2][SLICE_ROWS];

    wstate_t         wstate, wstate_n;
    rstate_t         rstate, rstate_n;
    logic [1:0]      full;
    logic            wr_bank, wr_bank_n, rd_bank, rd_bank_n;
    logic [RW-1:0]   wr_row, wr_row_n;
    logic [FW-1:0]   frame_row, frame_row_n;
    logic [KW-1:0]   k, k_n;
    logic [SW-1:0]   slice_n;
    logic            done_n;
    logic            set_full, clr_full, wr_en, wr_zero;
    logic            in_fire, out_fire, last_row, beat_last;

    assign in_ready  = rst_n && en && (wstate == W_FILL) && !full[wr_bank];
    assign in_fire   = in_valid && in_ready;
    assign last_row  = (frame_row == FW'(ROW - 1));

    // A full read bank is presented immediately, so the first beat follows the
    // filling handshake by one cycle and back-to-back slices have no bubble.
    assign out_valid = rst_n && full[rd_bank];
    assign out_fire  = out_valid && out_ready;
    assign beat_last = (k == KW'(CHUNKS_PER_ROW - 1));
    assign out_last  = out_valid && beat_last;

    always_comb begin
        wstate_n    = wstate;
        wr_bank_n   = wr_bank;
        wr_row_n    = wr_row;
        frame_row_n = frame_row;
        set_full    = 1'b0;
        wr_en       = 1'b0;
        wr_zero     = 1'b0;
        case (wstate)
            W_FILL: begin
                if (in_fire) begin
                    wr_en       = 1'b1;
                    frame_row_n = last_row ? '0 : frame_row + 1'b1;
                    if (last_row && PAD_ROWS > 0) begin
                        wstate_n = W_PAD;
                        wr_row_n = wr_row + 1'b1;
                    end else if (last_row || wr_row == RW'(SLICE_ROWS - 1)) begin
                        set_full  = 1'b1;
                        wr_bank_n = ~wr_bank;
                        wr_row_n  = '0;
                    end else begin
                        wr_row_n = wr_row + 1'b1;
                    end
                end
            end
            W_PAD: begin
                if (en) begin
                    wr_en   = 1'b1;
                    wr_zero = 1'b1;
                    if (wr_row == RW'(SLICE_ROWS - 1)) begin
                        set_full  = 1'b1;
                        wr_bank_n = ~wr_bank;
                        wr_row_n  = '0;
                        wstate_n  = W_FILL;
                    end else begin
                        wr_row_n = wr_row + 1'b1;
                    end
                end
            end
            default: wstate_n = W_FILL;
        endcase
    end

    always_comb begin
        rstate_n  = rstate;
        rd_bank_n = rd_bank;
        k_n       = k;
        slice_n   = slice_idx;
        done_n    = 1'b0;
        clr_full  = 1'b0;
        if (out_fire) begin
            if (beat_last) begin
                clr_full  = 1'b1;
                rd_bank_n = ~rd_bank;
                k_n       = '0;
                rstate_n  = full[~rd_bank] ? R_OUT : R_IDLE;
                if (slice_idx == SW'(NUM_SLICES - 1)) begin
                    slice_n = '0;
                    done_n  = 1'b1;
                end else begin
                    slice_n = slice_idx + 1'b1;
                end
            end else begin
                k_n      = k + 1'b1;
                rstate_n = R_OUT;
            end
        end else if (rstate == R_IDLE && full[rd_bank]) begin
            rstate_n = R_OUT;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wstate     <= W_FILL;
            rstate     <= R_IDLE;
            full       <= '0;
            wr_bank    <= 1'b0;
            rd_bank    <= 1'b0;
            wr_row     <= '0;
            frame_row  <= '0;
            k          <= '0;
            slice_idx  <= '0;
            frame_done <= 1'b0;
        end else begin
            wstate     <= wstate_n;
            rstate     <= rstate_n;
            wr_bank    <= wr_bank_n;
            rd_bank    <= rd_bank_n;
            wr_row     <= wr_row_n;
            frame_row  <= frame_row_n;
            k          <= k_n;
            slice_idx  <= slice_n;
            frame_done <= done_n;
            // Writer only fills an empty bank and reader only releases a full one,
            // so these never target the same bank in one cycle.
            if (set_full) full[wr_bank] <= 1'b1;
            if (clr_full) full[rd_bank] <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_bank][wr_row] <= wr_zero ? '0 : in_data;
    end

    always_comb begin
        out_data = '0;
        if (out_valid) begin
            for (int c = 0; c < NUM_CORES; c++) begin
                for (int r = 0; r < BLOCK_SIZE; r++) begin
                    for (int j = 0; j < BLOCK_SIZE; j++) begin
                        out_data[(NUM_CORES-1-c)*CW + (CHUNK_SIZE-1-(r*BLOCK_SIZE+j))*WIDTH +: WIDTH] =
                            mem[rd_bank][RW'(c*BLOCK_SIZE + r)][(COL-1-(int'(k)*BLOCK_SIZE+j))*WIDTH +: WIDTH];
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_n2r_buffer_stream.sv
// Directed bench for n2r_buffer_stream: ROW=10 (padded) and ROW=8 (exact) instances.
module tb_n2r_buffer_stream;

    localparam int DW = 128;
    localparam int IW = 128;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic en = 1'b1;
    logic in_valid [2];
    logic in_ready [2];
    logic [IW-1:0] in_data [2];
    logic out_valid [2];
    logic out_ready [2];
    logic [DW-1:0] out_data [2];
    logic out_last [2];
    logic frame_done [2];
    logic [2:0] slice_idx_a;
    logic [1:0] slice_idx_b;

    always #5 clk = ~clk;

    n2r_buffer_stream dut (
        .clk(clk), .rst_n(rst_n), .en(en),
        .in_valid(in_valid[0]), .in_ready(in_ready[0]), .in_data(in_data[0]),
        .out_valid(out_valid[0]), .out_ready(out_ready[0]), .out_data(out_data[0]),
        .out_last(out_last[0]), .frame_done(frame_done[0]), .slice_idx(slice_idx_a)
    );

    n2r_buffer_stream #(.ROW(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .en(en),
        .in_valid(in_valid[1]), .in_ready(in_ready[1]), .in_data(in_data[1]),
        .out_valid(out_valid[1]), .out_ready(out_ready[1]), .out_data(out_data[1]),
        .out_last(out_last[1]), .frame_done(frame_done[1]), .slice_idx(slice_idx_b)
    );

    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;
    int rp [2], rows_left [2], es [2], ek [2], beats [2], fd_cnt [2];
    int fd_cyc [2], first_vcyc [2], r3cyc [2], stall [2];
    bit fd_pend [2];
    bit ordy [2];
    bit en_pol;
    logic [DW-1:0] capt [12];

    function automatic int rows_of(input int d);
        return (d == 0) ? 10 : 8;
    endfunction

    function automatic int nslices(input int d);
        return (d == 0) ? 3 : 2;
    endfunction

    // Row i, column j carries 16*i + j; column 0 is the most significant field.
    function automatic logic [IW-1:0] row_word(input int i);
        logic [IW-1:0] w;
        w = '0;
        for (int j = 0; j < 8; j++) w[(7-j)*16 +: 16] = 16'(16*i + j);
        return w;
    endfunction

    function automatic logic [DW-1:0] exp_beat(input int rows, input int s, input int kk);
        logic [DW-1:0] v;
        int row, col, e;
        v = '0;
        for (int c = 0; c < 2; c++)
            for (int r = 0; r < 2; r++)
                for (int j = 0; j < 2; j++) begin
                    row = s*4 + c*2 + r;
                    col = kk*2 + j;
                    e   = r*2 + j;
                    v[(1-c)*64 + (3-e)*16 +: 16] = (row < rows) ? 16'(16*row + col) : 16'd0;
                end
        return v;
    endfunction

    task automatic chk(input string tag, input int obs, input int exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_d(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic clear_model(input int d, input int nrows);
        rp[d] = 0; rows_left[d] = nrows; es[d] = 0; ek[d] = 0; beats[d] = 0;
        fd_cnt[d] = 0; fd_cyc[d] = -1; first_vcyc[d] = -1; r3cyc[d] = -1;
        stall[d] = 0; fd_pend[d] = 1'b0;
    endtask

    // Inputs change at the falling edge; outputs are sampled 1 time unit later,
    // well before the rising edge that completes this cycle's handshakes.
    task automatic cycle();
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            in_valid[d]  = rows_left[d] > 0;
            in_data[d]   = row_word(rp[d]);
            out_ready[d] = ordy[d];
        end
        en = en_pol;
        #1;
        cyc++;
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("dut%0d frame_done cyc%0d", d, cyc), int'(frame_done[d]), int'(fd_pend[d]));
            fd_pend[d] = 1'b0;
            if (frame_done[d]) begin
                fd_cnt[d]++;
                if (fd_cnt[d] == 1) fd_cyc[d] = cyc;
            end
            if (out_valid[d] && first_vcyc[d] < 0) first_vcyc[d] = cyc;
            if (in_valid[d] && !in_ready[d]) stall[d]++;
            if (in_valid[d] && in_ready[d]) begin
                if (rp[d] == 3 && r3cyc[d] < 0) r3cyc[d] = cyc;
                rp[d] = (rp[d] + 1) % rows_of(d);
                rows_left[d]--;
            end
            if (out_valid[d] && out_ready[d]) begin
                chk_d($sformatf("dut%0d s%0d k%0d data", d, es[d], ek[d]), out_data[d],
                      exp_beat(rows_of(d), es[d], ek[d]));
                chk($sformatf("dut%0d s%0d k%0d last", d, es[d], ek[d]), int'(out_last[d]), int'(ek[d] == 3));
                chk($sformatf("dut%0d s%0d k%0d slice_idx", d, es[d], ek[d]),
                    (d == 0) ? int'(slice_idx_a) : int'(slice_idx_b), es[d]);
                if (d == 0) capt[es[0]*4 + ek[0]] = out_data[0];
                beats[d]++;
                if (ek[d] == 3) begin
                    ek[d] = 0;
                    if (es[d] == nslices(d) - 1) begin
                        es[d] = 0;
                        fd_pend[d] = 1'b1;
                    end else es[d]++;
                end else ek[d]++;
            end
        end
    endtask

    task automatic do_reset(input int na, input int nb);
        rst_n = 1'b0;
        in_valid[0] = 1'b0;
        in_valid[1] = 1'b0;
        @(posedge clk);
        #1;
        chk("rst out_valid", int'(out_valid[0]), 0);
        chk("rst in_ready", int'(in_ready[0]), 0);
        chk("rst slice_idx", int'(slice_idx_a), 0);
        chk("rst frame_done", int'(frame_done[0]), 0);
        chk("rst out_last", int'(out_last[0]), 0);
        chk_d("rst out_data", out_data[0], '0);
        chk("rst dut8 out_valid", int'(out_valid[1]), 0);
        rst_n = 1'b1;
        clear_model(0, na);
        clear_model(1, nb);
    endtask

    task automatic run_frames(input int d, input int n, input int budget, input string tag);
        int c;
        c = 0;
        while (fd_cnt[d] < n && c < budget) begin
            cycle();
            c++;
        end
        chk({tag, " frame completes"}, int'(fd_cnt[d] >= n), 1);
    endtask

    initial begin
        int c;
        en_pol = 1'b1;
        for (int d = 0; d < 2; d++) begin
            ordy[d] = 1'b1; out_ready[d] = 1'b1; in_valid[d] = 1'b0; in_data[d] = '0;
        end

        // Scenario 1/2: continuous stream, ROW=10
        do_reset(10, 0);
        run_frames(0, 1, 60, "s1");
        repeat (4) cycle();
        chk("s1 beats", beats[0], 12);
        chk("s1 frame_done count", fd_cnt[0], 1);
        chk("s1 first beat latency", first_vcyc[0] - r3cyc[0], 1);
        chk("s1 no bubble span", fd_cyc[0] - first_vcyc[0], 12);
        chk("s1 in stalls", stall[0], 0);
        chk_d("s1 slice0 beat0", capt[0], 128'h0000_0001_0010_0011_0020_0021_0030_0031);
        chk_d("s1 slice1 beat1", capt[5], 128'h0042_0043_0052_0053_0062_0063_0072_0073);
        chk_d("s1 slice2 beat0", capt[8], 128'h0080_0081_0090_0091_0000_0000_0000_0000);

        // Scenario 3: out_ready held low at slice 0 beat 2
        do_reset(10, 0);
        c = 0;
        while (!(es[0] == 0 && ek[0] == 2) && c < 40) begin cycle(); c++; end
        chk("s3 reach beat2", int'(es[0] == 0 && ek[0] == 2), 1);
        ordy[0] = 1'b0;
        repeat (5) begin
            cycle();
            chk("s3 hold valid", int'(out_valid[0]), 1);
            chk("s3 hold last", int'(out_last[0]), 0);
            chk_d("s3 hold data", out_data[0], exp_beat(10, 0, 2));
        end
        ordy[0] = 1'b1;
        run_frames(0, 1, 80, "s3");
        chk("s3 writer blocked", int'(stall[0] > 0), 1);
        chk("s3 beats", beats[0], 12);

        // Scenario 4: reset pulse in the middle of slice 1, then a fresh frame
        do_reset(10, 0);
        c = 0;
        while (!(es[0] == 1 && ek[0] == 1) && c < 40) begin cycle(); c++; end
        chk("s4 reach slice1", int'(es[0] == 1 && ek[0] == 1), 1);
        do_reset(10, 0);
        run_frames(0, 1, 60, "s4");
        chk("s4 beats", beats[0], 12);
        chk("s4 span", fd_cyc[0] - first_vcyc[0], 12);
        chk_d("s4 slice0 beat0", capt[0], 128'h0000_0001_0010_0011_0020_0021_0030_0031);
        chk_d("s4 slice2 beat3", capt[11], 128'h0086_0087_0096_0097_0000_0000_0000_0000);

        // Scenario 6: en low for 3 cycles with rows pending
        do_reset(10, 0);
        c = 0;
        while (rp[0] < 2 && c < 20) begin cycle(); c++; end
        chk("s6 two rows in", rp[0], 2);
        en_pol = 1'b0;
        repeat (3) begin
            cycle();
            chk("s6 en0 in_ready", int'(in_ready[0]), 0);
        end
        chk("s6 no rows while disabled", rp[0], 2);
        en_pol = 1'b1;
        run_frames(0, 1, 60, "s6");
        chk("s6 beats", beats[0], 12);

        // Scenario 5: ROW=8, two back-to-back frames without reset
        do_reset(0, 16);
        run_frames(1, 2, 100, "s5");
        repeat (2) cycle();
        chk("s5 beats", beats[1], 16);
        chk("s5 frame_done count", fd_cnt[1], 2);
        chk("s5 first frame span", fd_cyc[1] - first_vcyc[1], 8);
        chk("s5 in stalls", stall[1], 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
